// File: rtl/huffman_table_loader.sv
// huffman_table_loader: turns a UART byte stream (rx_data/data_ready/uart errors -> data_read) into lookup-table writes (wr_*/wr_ack) with status outputs (entry_count, table_done/decode_done, load_error/err_code)
module huffman_table_loader #(
  parameter int PATH_W = 16,
  parameter int LEN_W = 5,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter logic [7:0] EOT_CODE = 8'hFF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        rx_data,
  input  logic              data_ready,
  input  logic              overrun_error,
  input  logic              framing_error,
  output logic              data_read,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_sym,
  output logic [LEN_W-1:0]  wr_len,
  output logic [PATH_W-1:0] wr_path,
  input  logic              wr_ack,
  output logic [ADDR_W:0]   entry_count,
  output logic              table_done,
  input  logic              decode_done,
  output logic              load_error,
  output logic [1:0]        err_code
);
  localparam int PATH_BYTES = (PATH_W + 7) / 8;
  localparam int CNT_W = PATH_BYTES > 1 ? $clog2(PATH_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, GET_SYM, GET_LEN, GET_PATH, WRITE, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [7:0] sym_q, sym_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PATH_BYTES*8-1:0] path_q, path_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0] count_q, count_d, count_inc;
  logic [1:0] err_q, err_d;
  logic uart_err, getting, full;
  assign uart_err = overrun_error | framing_error;
  assign getting = state_q == GET_SYM || state_q == GET_LEN || state_q == GET_PATH;
  assign count_inc = count_q + 1'b1;
  assign full = count_inc == (ADDR_W+1)'(DEPTH);
  assign data_read = getting & data_ready & ~uart_err;
  assign wr_en = state_q == WRITE;
  assign wr_addr = count_q[ADDR_W-1:0];
  assign wr_sym = sym_q;
  assign wr_len = len_q;
  assign wr_path = path_q[PATH_W-1:0] & ~({PATH_W{1'b1}} << len_q);
  assign entry_count = count_q;
  assign table_done = state_q == DONE;
  assign load_error = state_q == ERROR;
  assign err_code = err_q;
  always_comb begin
    state_d = state_q;
    sym_d = sym_q;
    len_d = len_q;
    path_d = path_q;
    cnt_d = cnt_q;
    count_d = count_q;
    err_d = err_q;
    if (getting && uart_err) begin
      state_d = ERROR;
      err_d = 2'b01;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (data_ready) begin
            err_d = 2'b00;
            state_d = GET_SYM;
          end
        end
        GET_SYM: if (data_ready) begin
          sym_d = rx_data;
          state_d = GET_LEN;
        end
        GET_LEN: if (data_ready) begin
          if (rx_data == EOT_CODE) state_d = DONE;
          else if (rx_data == 8'd0 || int'(rx_data) > PATH_W) begin
            state_d = ERROR;
            err_d = 2'b10;
          end else begin
            len_d = rx_data[LEN_W-1:0];
            cnt_d = '0;
            state_d = GET_PATH;
          end
        end
        GET_PATH: if (data_ready) begin
          path_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 1'b1;
          state_d = cnt_q == CNT_W'(PATH_BYTES - 1) ? WRITE : GET_PATH;
        end
        WRITE: if (wr_ack) begin
          count_d = count_inc;
          state_d = full ? ERROR : GET_SYM;
          err_d = full ? 2'b11 : err_q;
        end
        DONE: if (decode_done) begin
          count_d = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sym_q <= '0;
      len_q <= '0;
      path_q <= '0;
      cnt_q <= '0;
      count_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      sym_q <= sym_d;
      len_q <= len_d;
      path_q <= path_d;
      cnt_q <= cnt_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_huffman_table_loader.sv
// tb_huffman_table_loader: directed self-checking bench for huffman_table_loader (PATH_W=16, DEPTH=4)
module tb_huffman_table_loader;
  logic clk = 0;
  logic n_rst;
  logic [7:0] rx_data;
  logic data_ready, overrun_error, framing_error, data_read, wr_en, wr_ack;
  logic [1:0] wr_addr;
  logic [7:0] wr_sym;
  logic [4:0] wr_len;
  logic [15:0] wr_path;
  logic [2:0] entry_count;
  logic table_done, decode_done, load_error;
  logic [1:0] err_code;
  int checks = 0, errors = 0, nwr = 0, ack_delay = 1, hcnt = 0;
  logic [30:0] wlog [16];
  logic [30:0] held;
  huffman_table_loader #(.PATH_W(16), .LEN_W(5), .DEPTH(4), .ADDR_W(2), .EOT_CODE(8'hFF)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .framing_error(framing_error), .data_read(data_read),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sym(wr_sym), .wr_len(wr_len), .wr_path(wr_path),
    .wr_ack(wr_ack), .entry_count(entry_count), .table_done(table_done),
    .decode_done(decode_done), .load_error(load_error), .err_code(err_code)
  );
  always #5 clk = ~clk;
  initial begin
    wr_ack = 0;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        checks++;
        if (data_read !== 1'b0) begin
          errors++;
          $display("FAIL write_no_read: data_read=%b required 0", data_read);
        end
        if (hcnt == 0) held = {wr_addr, wr_sym, wr_len, wr_path};
        else begin
          checks++;
          if ({wr_addr, wr_sym, wr_len, wr_path} !== held) begin
            errors++;
            $display("FAIL write_stable: got %h required %h", {wr_addr, wr_sym, wr_len, wr_path}, held);
          end
        end
        hcnt++;
        if (hcnt > ack_delay) begin
          wr_ack = 1;
          if (nwr < 16) wlog[nwr] = held;
          nwr++;
          hcnt = 0;
        end
      end else begin
        wr_ack = 0;
        hcnt = 0;
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    data_ready = 1;
    @(negedge clk);
    while (!data_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (data_read !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_%h: data_read=%b required 1 within 50 cycles", b, data_read);
    end
    @(posedge clk);
    #1 data_ready = 0;
  endtask
  task automatic end_table;
    @(posedge clk);
    #1 decode_done = 1;
    @(posedge clk);
    #1 decode_done = 0;
  endtask
  task automatic test_reset;
    n_rst = 0;
    rx_data = 0;
    data_ready = 0;
    overrun_error = 0;
    framing_error = 0;
    decode_done = 0;
    #12;
    checks++;
    if ({data_read, wr_en, wr_addr, wr_sym, wr_len, wr_path, entry_count, table_done, load_error, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {data_read, wr_en, wr_addr, wr_sym, wr_len, wr_path, entry_count, table_done, load_error, err_code});
    end
    @(posedge clk);
    #1 n_rst = 1;
    @(negedge clk);
    checks++;
    if ({table_done, load_error, err_code, entry_count, wr_en} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h required 0", {table_done, load_error, err_code, entry_count, wr_en});
    end
  endtask
  task automatic test_basic;
    logic [7:0] s [10] = '{8'h41, 8'h03, 8'h05, 8'h00, 8'h42, 8'h02, 8'h01, 8'h00, 8'h00, 8'hFF};
    int base = nwr;
    ack_delay = 1;
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    @(negedge clk);
    checks++;
    if (nwr - base != 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d required 2", nwr - base);
    end
    checks++;
    if (wlog[base] !== {2'd0, 8'h41, 5'd3, 16'h0005}) begin
      errors++;
      $display("FAIL basic_entry0: got %h required %h", wlog[base], {2'd0, 8'h41, 5'd3, 16'h0005});
    end
    checks++;
    if (wlog[base+1] !== {2'd1, 8'h42, 5'd2, 16'h0001}) begin
      errors++;
      $display("FAIL basic_entry1: got %h required %h", wlog[base+1], {2'd1, 8'h42, 5'd2, 16'h0001});
    end
    checks++;
    if (table_done !== 1'b1 || entry_count !== 3'd2) begin
      errors++;
      $display("FAIL basic_done: table_done=%b entry_count=%0d required 1 and 2", table_done, entry_count);
    end
    @(negedge clk);
    checks++;
    if (table_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_held: table_done=%b required 1", table_done);
    end
    end_table;
    @(negedge clk);
    checks++;
    if (table_done !== 1'b0 || entry_count !== 3'd0) begin
      errors++;
      $display("FAIL basic_rearm: table_done=%b entry_count=%0d required 0 and 0", table_done, entry_count);
    end
  endtask
  task automatic test_mask;
    logic [7:0] s [6] = '{8'h43, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    int base = nwr;
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    @(negedge clk);
    checks++;
    if (nwr - base != 1 || wlog[base] !== {2'd0, 8'h43, 5'd3, 16'h0007}) begin
      errors++;
      $display("FAIL mask_entry: writes=%0d got %h required 1 and %h", nwr - base, wlog[base], {2'd0, 8'h43, 5'd3, 16'h0007});
    end
    end_table;
  endtask
  task automatic test_bad_length;
    int base = nwr;
    send_byte(8'h44);
    send_byte(8'h11);
    @(negedge clk);
    checks++;
    if (load_error !== 1'b1 || err_code !== 2'b10 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL badlen_pulse: load_error=%b err_code=%b wr_en=%b required 1 10 0", load_error, err_code, wr_en);
    end
    @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || err_code !== 2'b10 || nwr != base) begin
      errors++;
      $display("FAIL badlen_after: load_error=%b err_code=%b writes=%0d required 0 10 0", load_error, err_code, nwr - base);
    end
    send_byte(8'h45);
    checks++;
    if (err_code !== 2'b00) begin
      errors++;
      $display("FAIL err_cleared_on_load: err_code=%b required 00", err_code);
    end
    send_byte(8'h00);
    @(negedge clk);
    checks++;
    if (load_error !== 1'b1 || err_code !== 2'b10) begin
      errors++;
      $display("FAIL zerolen_pulse: load_error=%b err_code=%b required 1 10", load_error, err_code);
    end
  endtask
  task automatic test_uart_error;
    int base = nwr;
    send_byte(8'h46);
    send_byte(8'h08);
    send_byte(8'hAA);
    rx_data = 8'hBB;
    data_ready = 1;
    framing_error = 1;
    @(negedge clk);
    checks++;
    if (data_read !== 1'b0) begin
      errors++;
      $display("FAIL uart_no_consume: data_read=%b required 0", data_read);
    end
    @(posedge clk);
    #1 data_ready = 0;
    framing_error = 0;
    @(negedge clk);
    checks++;
    if (load_error !== 1'b1 || err_code !== 2'b01) begin
      errors++;
      $display("FAIL uart_pulse: load_error=%b err_code=%b required 1 01", load_error, err_code);
    end
    @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || err_code !== 2'b01 || nwr != base) begin
      errors++;
      $display("FAIL uart_after: load_error=%b err_code=%b writes=%0d required 0 01 0", load_error, err_code, nwr - base);
    end
    send_byte(8'h4A);
    rx_data = 8'h03;
    data_ready = 1;
    overrun_error = 1;
    @(posedge clk);
    #1 data_ready = 0;
    overrun_error = 0;
    @(negedge clk);
    checks++;
    if (load_error !== 1'b1 || err_code !== 2'b01) begin
      errors++;
      $display("FAIL overrun_pulse: load_error=%b err_code=%b required 1 01", load_error, err_code);
    end
  endtask
  task automatic test_full;
    logic [7:0] s [6] = '{8'h54, 8'h04, 8'h15, 8'h00, 8'h00, 8'hFF};
    int base = nwr;
    int n = 0;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h50 + 8'(i));
      send_byte(8'h04);
      send_byte(8'h10 + 8'(i));
      send_byte(8'h00);
    end
    @(negedge clk);
    while (!load_error && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (load_error !== 1'b1 || err_code !== 2'b11 || entry_count !== 3'd4) begin
      errors++;
      $display("FAIL full_error: load_error=%b err_code=%b entry_count=%0d required 1 11 4", load_error, err_code, entry_count);
    end
    checks++;
    if (nwr - base != 4) begin
      errors++;
      $display("FAIL full_write_count: got %0d required 4", nwr - base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wlog[base+i] !== {2'(i), 8'h50 + 8'(i), 5'd4, 16'(i)}) begin
        errors++;
        $display("FAIL full_entry%0d: got %h required %h", i, wlog[base+i], {2'(i), 8'h50 + 8'(i), 5'd4, 16'(i)});
      end
    end
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    @(negedge clk);
    checks++;
    if (err_code !== 2'b00 || wlog[base+4] !== {2'd0, 8'h54, 5'd4, 16'h0005} || entry_count !== 3'd1 || table_done !== 1'b1) begin
      errors++;
      $display("FAIL full_next_table: err_code=%b entry=%h count=%0d done=%b required 00 %h 1 1", err_code, wlog[base+4], entry_count, table_done, {2'd0, 8'h54, 5'd4, 16'h0005});
    end
    end_table;
    ack_delay = 1;
  endtask
  task automatic test_backpressure;
    logic [7:0] s [6] = '{8'h47, 8'h05, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    int base = nwr;
    ack_delay = 5;
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    @(negedge clk);
    checks++;
    if (nwr - base != 1 || wlog[base] !== {2'd0, 8'h47, 5'd5, 16'h001F} || table_done !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_entry: writes=%0d got %h done=%b required 1 %h 1", nwr - base, wlog[base], table_done, {2'd0, 8'h47, 5'd5, 16'h001F});
    end
    end_table;
    ack_delay = 1;
  endtask
  task automatic test_reset_mid;
    logic [7:0] s [7] = '{8'h48, 8'h06, 8'hAA, 8'hBB, 8'h49, 8'h06, 8'hCC};
    int base = nwr;
    for (int i = 0; i < 7; i++) send_byte(s[i]);
    checks++;
    if (wlog[base] !== {2'd0, 8'h48, 5'd6, 16'h002A} || entry_count !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset_entry: got %h count=%0d required %h 1", wlog[base], entry_count, {2'd0, 8'h48, 5'd6, 16'h002A});
    end
    rx_data = 8'hDD;
    data_ready = 1;
    #2 n_rst = 0;
    #1;
    checks++;
    if ({data_read, wr_en, wr_addr, wr_sym, wr_len, wr_path, entry_count, table_done, load_error, err_code} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {data_read, wr_en, wr_addr, wr_sym, wr_len, wr_path, entry_count, table_done, load_error, err_code});
    end
    @(posedge clk);
    #1 data_ready = 0;
    n_rst = 1;
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    checks++;
    if (table_done !== 1'b1 || entry_count !== 3'd0 || nwr != base + 1) begin
      errors++;
      $display("FAIL post_reset_table: done=%b count=%0d writes=%0d required 1 0 1", table_done, entry_count, nwr - base);
    end
    end_table;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_mask;
    test_bad_length;
    test_uart_error;
    test_full;
    test_backpressure;
    test_reset_mid;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/huffman_table_loader.md
Name: huffman_table_loader

Overview:
- Parametrised successor to the single-width Huffman lookup-table builder; consumes the serialized code table from the UART receiver and writes {symbol, code length, code path} entries into the lookup-table register file.
- Adds configurable path width and table depth, an explicit end-of-table marker, length validation, entry addressing and counting, table-full detection, and error reporting.
- Holds table_done until the decode block finishes, then re-arms for the next table.

Parameters:
PATH_W, 16, maximum code path width in bits (8..32)
LEN_W, 5, width of the stored length field; must satisfy 2^LEN_W > PATH_W
DEPTH, 256, maximum number of table entries
ADDR_W, 8, entry address width; must satisfy 2^ADDR_W >= DEPTH
EOT_CODE, 8'hFF, length byte value that terminates the table

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
rx_data  in  8  UART received byte
data_ready  in  1  UART byte valid
overrun_error  in  1  UART overrun flag
framing_error  in  1  UART framing flag
data_read  out  1  byte-consume strobe to UART
wr_en  out  1  table write request
wr_addr  out  ADDR_W  entry index
wr_sym  out  8  symbol
wr_len  out  LEN_W  code length
wr_path  out  PATH_W  code path, LSB first
wr_ack  in  1  register file accepted write
entry_count  out  ADDR_W+1  entries written this table
table_done  out  1  table complete, held
decode_done  in  1  decode block finished with table
load_error  out  1  one-cycle error pulse
err_code  out  2  00 none, 01 UART, 10 bad length, 11 table full; held until next load starts

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low. On reset all outputs are 0, the state is IDLE, and all internal registers clear.
- PATH_BYTES = ceil(PATH_W/8).
- Stream per entry: symbol byte, length byte, then PATH_BYTES path bytes, least-significant byte first. A length byte equal to EOT_CODE, in place of an entry's length, ends the table; the symbol byte preceding it is discarded.
- Byte consume: in GET_SYM, GET_LEN and GET_PATH, data_read = data_ready (combinational). The byte is latched on that clock edge. Exactly one byte is consumed per data_read cycle.
- IDLE:
  - Clears err_code and entry_count.
  - data_ready → GET_SYM. No byte is consumed in IDLE.
- GET_SYM: latch symbol → GET_LEN.
- GET_LEN:
  - EOT_CODE → DONE.
  - Length 0 or length > PATH_W → ERROR (code 10).
  - Otherwise latch length[LEN_W-1:0], clear byte counter → GET_PATH.
- GET_PATH:
  - Each byte is placed at path[8k+7:8k] for byte k.
  - After PATH_BYTES bytes → WRITE.
  - Path bits at index ≥ length are forced to 0 before writing. Bits beyond PATH_W in the last byte are dropped.
- WRITE:
  - wr_en=1, with wr_addr = entry_count and data fields held stable until wr_ack.
  - On the wr_ack cycle, entry_count increments and the next state is GET_SYM, or ERROR (code 11) if entry_count+1 == DEPTH.
  - No bytes are consumed in WRITE.
- DONE: table_done=1 until decode_done is sampled high, then → IDLE.
- ERROR:
  - load_error pulses for one cycle and err_code is set.
  - Entries already written are not rolled back.
  - → IDLE.
- UART error: overrun_error or framing_error high in GET_SYM, GET_LEN or GET_PATH → ERROR (code 01), and the current byte is not consumed. The UART error inputs are ignored in IDLE, WRITE and DONE.
- Simultaneous events: a UART error in the same cycle as data_ready gives error priority. decode_done outside DONE is ignored.
- Latency: the first wr_en is asserted the cycle after the last path byte is consumed.

Test Plan:
- PATH_W=16, stream 41,03,05,00 then 42,02,01,00 then 00,FF, wr_ack after 1 cycle → writes (addr0, sym41, len3, path0005) and (addr1, sym42, len2, path0001); table_done=1 and entry_count=2; decode_done pulse → IDLE, entry_count=0.
- Masking: 43,03,FF,FF → wr_path=0007.
- Bad length: 44,11 (17 > PATH_W) → load_error pulse, err_code=10, no wr_en.
- UART error: framing_error asserted during the second path byte → data_read=0 that cycle, err_code=01, IDLE.
- Full: DEPTH=4, five entries sent → four writes, then err_code=11 after the 4th wr_ack.
- Backpressure and reset: wr_ack delayed 5 cycles → wr_en and data held stable with data_read=0; n_rst asserted mid-GET_PATH → all outputs 0 immediately and IDLE on release.
